// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the RV32I memory stage: operation/size encodings,
// FSM states, alignment checks and store lane/strobe generation.
package load_store_unit_pkg;

  localparam int unsigned LSU_DATA_W = 32;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2,
    MEM_RSVD  = 2'd3
  } MemoryOperation_;

  typedef enum logic [2:0] {
    LS_BYTE   = 3'b000,
    LS_HALF   = 3'b001,
    LS_WORD   = 3'b010,
    LS_BYTE_U = 3'b100,
    LS_HALF_U = 3'b101
  } LoadStoreSize_;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_RESP,
    HOLD,
    DRAIN
  } LsuState_;

  // Illegal encodings (and unsigned variants on stores) fall back to a word access.
  function automatic LoadStoreSize_ decode_size(input logic [2:0] funct3, input logic is_store);
    LoadStoreSize_ size;
    case (funct3)
      3'b000:  size = LS_BYTE;
      3'b001:  size = LS_HALF;
      3'b100:  size = is_store ? LS_WORD : LS_BYTE_U;
      3'b101:  size = is_store ? LS_WORD : LS_HALF_U;
      default: size = LS_WORD;
    endcase
    return size;
  endfunction

  function automatic logic is_misaligned(input LoadStoreSize_ size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      LS_HALF, LS_HALF_U: mis = addr_lo[0];
      LS_WORD:            mis = (addr_lo != 2'b00);
      default:            mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_strobe(input LoadStoreSize_ size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      LS_BYTE: strb = 4'b0001 << addr_lo;
      LS_HALF: strb = 4'b0011 << addr_lo;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [LSU_DATA_W-1:0] store_lanes(input LoadStoreSize_ size,
                                                        input logic [LSU_DATA_W-1:0] data);
    logic [LSU_DATA_W-1:0] lanes;
    case (size)
      LS_BYTE: lanes = {4{data[7:0]}};
      LS_HALF: lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline (execute -> writeback) and data-bus signals of the load/store unit.
// slave is the LSU view; master is the surrounding pipeline/bus view.
interface load_store_unit_if
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  flush;
  logic                  inValid;
  logic                  inReady;
  MemoryOperation_       inMemOp;
  logic [2:0]            inFunct3;
  logic [ADDR_WIDTH-1:0] inAddress;
  logic [DATA_WIDTH-1:0] inStoreData;
  logic [4:0]            inRd;
  logic                  outValid;
  logic                  outReady;
  logic [DATA_WIDTH-1:0] outResult;
  logic [4:0]            outRd;
  logic                  outLoadMisaligned;
  logic                  outStoreMisaligned;
  logic                  busReqValid;
  logic                  busReqReady;
  logic                  busWrite;
  logic [ADDR_WIDTH-1:0] busAddress;
  logic [DATA_WIDTH-1:0] busWriteData;
  logic [3:0]            busWriteStrobe;
  logic                  busRespValid;
  logic [DATA_WIDTH-1:0] busRespData;

  modport slave (
    input  flush, inValid, inMemOp, inFunct3, inAddress, inStoreData, inRd,
    input  outReady, busReqReady, busRespValid, busRespData,
    output inReady, outValid, outResult, outRd, outLoadMisaligned, outStoreMisaligned,
    output busReqValid, busWrite, busAddress, busWriteData, busWriteStrobe
  );

  modport master (
    output flush, inValid, inMemOp, inFunct3, inAddress, inStoreData, inRd,
    output outReady, busReqReady, busRespValid, busRespData,
    input  inReady, outValid, outResult, outRd, outLoadMisaligned, outStoreMisaligned,
    input  busReqValid, busWrite, busAddress, busWriteData, busWriteStrobe
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [LSU_DATA_W-1:0] resp_data,
  input  logic [1:0]            addr_lo,
  input  LoadStoreSize_         size,
  output logic [LSU_DATA_W-1:0] load_data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = resp_data[{addr_lo, 3'b000} +: 8];
    half_sel = resp_data[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      LS_BYTE:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LS_BYTE_U: load_data = {24'h000000, byte_sel};
      LS_HALF:   load_data = {{16{half_sel[15]}}, half_sel};
      LS_HALF_U: load_data = {16'h0000, half_sel};
      default:   load_data = resp_data;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one bus transaction per load/store, passthrough for ALU ops,
// misalignment trapping and flush handling that never orphans a bus response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.slave lsu
);
  LsuState_              state_q, state_d;
  MemoryOperation_       memop_q, memop_d;
  LoadStoreSize_         size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            strobe_q, strobe_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [4:0]            rd_q, rd_d;
  logic                  load_mis_q, load_mis_d;
  logic                  store_mis_q, store_mis_d;

  LoadStoreSize_         in_size;
  logic                  in_mem, in_mis, in_ready, accept, bus_req, bus_store;
  logic [DATA_WIDTH-1:0] load_data;

  load_align u_load_align (
    .resp_data (lsu.busRespData),
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .load_data (load_data)
  );

  always_comb begin
    state_d     = state_q;
    memop_d     = memop_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strobe_d    = strobe_q;
    result_d    = result_q;
    rd_d        = rd_q;
    load_mis_d  = load_mis_q;
    store_mis_d = store_mis_q;

    in_size = decode_size(lsu.inFunct3, lsu.inMemOp == MEM_STORE);
    in_mem  = (lsu.inMemOp == MEM_LOAD) || (lsu.inMemOp == MEM_STORE);
    in_mis  = in_mem && is_misaligned(in_size, lsu.inAddress[1:0]);
    case (state_q)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = lsu.outReady;
      default: in_ready = 1'b0;
    endcase
    accept = lsu.inValid && in_ready && !lsu.flush;

    case (state_q)
      HOLD:
        if (lsu.flush || lsu.outReady) state_d = IDLE;
      REQUEST:
        if (lsu.flush)            state_d = lsu.busReqReady ? DRAIN : IDLE;
        else if (lsu.busReqReady) state_d = WAIT_RESP;
      WAIT_RESP:
        // A response coinciding with the flush is already consumed; no drain needed.
        if (lsu.flush) begin
          state_d = lsu.busRespValid ? IDLE : DRAIN;
        end else if (lsu.busRespValid) begin
          state_d  = HOLD;
          result_d = (memop_q == MEM_STORE) ? '0 : load_data;
        end
      DRAIN:
        if (lsu.busRespValid) state_d = IDLE;
      default: ;
    endcase

    // Accept overrides the HOLD -> IDLE exit, giving back-to-back issue.
    if (accept) begin
      memop_d     = lsu.inMemOp;
      size_d      = in_size;
      addr_d      = lsu.inAddress;
      rd_d        = lsu.inRd;
      wdata_d     = store_lanes(in_size, lsu.inStoreData);
      strobe_d    = store_strobe(in_size, lsu.inAddress[1:0]);
      load_mis_d  = in_mis && (lsu.inMemOp == MEM_LOAD);
      store_mis_d = in_mis && (lsu.inMemOp == MEM_STORE);
      if (!in_mem || in_mis) begin
        state_d  = HOLD;
        result_d = lsu.inAddress;
      end else begin
        state_d  = REQUEST;
        result_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      memop_q     <= MEM_NONE;
      size_q      <= LS_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      strobe_q    <= '0;
      result_q    <= '0;
      rd_q        <= '0;
      load_mis_q  <= 1'b0;
      store_mis_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      memop_q     <= memop_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strobe_q    <= strobe_d;
      result_q    <= result_d;
      rd_q        <= rd_d;
      load_mis_q  <= load_mis_d;
      store_mis_q <= store_mis_d;
    end
  end

  always_comb begin
    bus_req                = (state_q == REQUEST);
    bus_store              = bus_req && (memop_q == MEM_STORE);
    lsu.inReady            = in_ready;
    lsu.outValid           = (state_q == HOLD);
    lsu.outResult          = result_q;
    lsu.outRd              = rd_q;
    lsu.outLoadMisaligned  = load_mis_q;
    lsu.outStoreMisaligned = store_mis_q;
    lsu.busReqValid        = bus_req;
    lsu.busWrite           = bus_store;
    lsu.busAddress         = bus_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    lsu.busWriteData       = bus_store ? wdata_q : '0;
    lsu.busWriteStrobe     = bus_store ? strobe_q : '0;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors for passthrough,
// loads, stores, misalignment, stalls, back-to-back issue and flush.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clock = ~clock;

  load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) lsu_if ();

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .lsu   (lsu_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input MemoryOperation_ op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd);
    lsu_if.inValid     = 1'b1;
    lsu_if.inMemOp     = op;
    lsu_if.inFunct3    = f3;
    lsu_if.inAddress   = addr;
    lsu_if.inStoreData = data;
    lsu_if.inRd        = rd;
  endtask

  // Accept, one-cycle bus handshake, response next cycle, then check the writeback word.
  task automatic load_seq(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp_bus_addr, input logic [31:0] resp,
                          input logic [31:0] exp);
    drive(MEM_LOAD, f3, addr, 32'h0, 5'd9);
    tick();
    lsu_if.inValid = 1'b0;
    #1;
    check({tag, "_req"}, {31'd0, lsu_if.busReqValid}, 32'd1);
    check({tag, "_addr"}, lsu_if.busAddress, exp_bus_addr);
    check({tag, "_wr"}, {31'd0, lsu_if.busWrite}, 32'd0);
    tick();
    lsu_if.busRespValid = 1'b1;
    lsu_if.busRespData  = resp;
    tick();
    lsu_if.busRespValid = 1'b0;
    lsu_if.busRespData  = '0;
    #1;
    check({tag, "_ovalid"}, {31'd0, lsu_if.outValid}, 32'd1);
    check({tag, "_result"}, lsu_if.outResult, exp);
    tick();
  endtask

  task automatic store_seq(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    drive(MEM_STORE, f3, addr, data, 5'd0);
    tick();
    lsu_if.inValid = 1'b0;
    #1;
    check({tag, "_wr"}, {31'd0, lsu_if.busWrite}, 32'd1);
    check({tag, "_addr"}, lsu_if.busAddress, exp_addr);
    check({tag, "_strb"}, {28'd0, lsu_if.busWriteStrobe}, {28'd0, exp_strb});
    check({tag, "_wdata"}, lsu_if.busWriteData, exp_wdata);
    tick();
    lsu_if.busRespValid = 1'b1;
    tick();
    lsu_if.busRespValid = 1'b0;
    #1;
    check({tag, "_ovalid"}, {31'd0, lsu_if.outValid}, 32'd1);
    check({tag, "_result"}, lsu_if.outResult, 32'h0);
    tick();
  endtask

  initial begin
    lsu_if.flush        = 1'b0;
    lsu_if.inValid      = 1'b0;
    lsu_if.inMemOp      = MEM_NONE;
    lsu_if.inFunct3     = 3'b000;
    lsu_if.inAddress    = '0;
    lsu_if.inStoreData  = '0;
    lsu_if.inRd         = '0;
    lsu_if.outReady     = 1'b1;
    lsu_if.busReqReady  = 1'b1;
    lsu_if.busRespValid = 1'b0;
    lsu_if.busRespData  = '0;

    tick();
    tick();
    check("rst_inready", {31'd0, lsu_if.inReady}, 32'd1);
    check("rst_ovalid", {31'd0, lsu_if.outValid}, 32'd0);
    check("rst_breq", {31'd0, lsu_if.busReqValid}, 32'd0);
    check("rst_result", lsu_if.outResult, 32'h0);
    reset = 1'b1;
    tick();

    // ALU passthrough
    drive(MEM_NONE, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
    tick();
    lsu_if.inValid = 1'b0;
    #1;
    check("none_ovalid", {31'd0, lsu_if.outValid}, 32'd1);
    check("none_result", lsu_if.outResult, 32'h1234_5678);
    check("none_rd", {27'd0, lsu_if.outRd}, 32'd5);
    check("none_breq", {31'd0, lsu_if.busReqValid}, 32'd0);
    tick();
    check("none_idle", {31'd0, lsu_if.outValid}, 32'd0);

    load_seq("lb", 3'b000, 32'h0000_0103, 32'h0000_0100, 32'h80FF_0011, 32'hFFFF_FF80);
    load_seq("lbu", 3'b100, 32'h0000_0103, 32'h0000_0100, 32'h80FF_0011, 32'h0000_0080);
    load_seq("lb0", 3'b000, 32'h0000_0100, 32'h0000_0100, 32'h80FF_0011, 32'h0000_0011);
    load_seq("lh", 3'b001, 32'h0000_0102, 32'h0000_0100, 32'h80FF_0011, 32'hFFFF_80FF);
    load_seq("lhu", 3'b101, 32'h0000_0102, 32'h0000_0100, 32'h80FF_0011, 32'h0000_80FF);
    load_seq("lw", 3'b010, 32'h0000_0104, 32'h0000_0104, 32'h80FF_0011, 32'h80FF_0011);
    load_seq("lill", 3'b111, 32'h0000_0108, 32'h0000_0108, 32'h1357_9BDF, 32'h1357_9BDF);

    store_seq("sh", 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
    store_seq("sb", 3'b000, 32'h0000_0201, 32'h1234_56EF, 32'h0000_0200, 4'b0010, 32'hEFEF_EFEF);
    store_seq("sw", 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D);

    // Misaligned load and store trap without touching the bus
    drive(MEM_LOAD, 3'b010, 32'h0000_0102, 32'h0, 5'd3);
    tick();
    lsu_if.inValid = 1'b0;
    #1;
    check("lwmis_ovalid", {31'd0, lsu_if.outValid}, 32'd1);
    check("lwmis_flag", {31'd0, lsu_if.outLoadMisaligned}, 32'd1);
    check("lwmis_sflag", {31'd0, lsu_if.outStoreMisaligned}, 32'd0);
    check("lwmis_breq", {31'd0, lsu_if.busReqValid}, 32'd0);
    check("lwmis_result", lsu_if.outResult, 32'h0000_0102);
    tick();
    drive(MEM_STORE, 3'b001, 32'h0000_0201, 32'h0, 5'd0);
    tick();
    lsu_if.inValid = 1'b0;
    #1;
    check("shmis_sflag", {31'd0, lsu_if.outStoreMisaligned}, 32'd1);
    check("shmis_lflag", {31'd0, lsu_if.outLoadMisaligned}, 32'd0);
    check("shmis_breq", {31'd0, lsu_if.busReqValid}, 32'd0);
    tick();

    // Bus stall, writeback stall, then back-to-back accept on the outReady handshake
    lsu_if.busReqReady = 1'b0;
    drive(MEM_LOAD, 3'b010, 32'h0000_0104, 32'h0, 5'd11);
    tick();
    lsu_if.inValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_breq", {31'd0, lsu_if.busReqValid}, 32'd1);
      check("stall_addr", lsu_if.busAddress, 32'h0000_0104);
      check("stall_inready", {31'd0, lsu_if.inReady}, 32'd0);
      if (i < 2) tick();
    end
    lsu_if.busReqReady = 1'b1;
    tick();
    lsu_if.outReady     = 1'b0;
    lsu_if.busRespValid = 1'b1;
    lsu_if.busRespData  = 32'hDEAD_BEEF;
    tick();
    lsu_if.busRespValid = 1'b0;
    lsu_if.busRespData  = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("ostall_valid", {31'd0, lsu_if.outValid}, 32'd1);
      check("ostall_result", lsu_if.outResult, 32'hDEAD_BEEF);
      check("ostall_rd", {27'd0, lsu_if.outRd}, 32'd11);
      check("ostall_inready", {31'd0, lsu_if.inReady}, 32'd0);
      tick();
    end
    lsu_if.outReady = 1'b1;
    drive(MEM_NONE, 3'b000, 32'hCAFE_0001, 32'h0, 5'd7);
    #1;
    check("b2b_inready", {31'd0, lsu_if.inReady}, 32'd1);
    tick();
    lsu_if.inValid = 1'b0;
    #1;
    check("b2b_valid", {31'd0, lsu_if.outValid}, 32'd1);
    check("b2b_result", lsu_if.outResult, 32'hCAFE_0001);
    check("b2b_rd", {27'd0, lsu_if.outRd}, 32'd7);
    tick();

    // Flush while waiting for the response: drain it, never present it
    drive(MEM_LOAD, 3'b010, 32'h0000_0108, 32'h0, 5'd4);
    tick();
    lsu_if.inValid = 1'b0;
    tick();
    lsu_if.flush = 1'b1;
    tick();
    lsu_if.flush = 1'b0;
    #1;
    check("drain_inready", {31'd0, lsu_if.inReady}, 32'd0);
    check("drain_ovalid", {31'd0, lsu_if.outValid}, 32'd0);
    lsu_if.busRespValid = 1'b1;
    lsu_if.busRespData  = 32'h5555_AAAA;
    tick();
    lsu_if.busRespValid = 1'b0;
    #1;
    check("drain_done_inready", {31'd0, lsu_if.inReady}, 32'd1);
    check("drain_done_ovalid", {31'd0, lsu_if.outValid}, 32'd0);
    tick();

    // Flush in REQUEST with the bus not ready: request withdrawn, straight to IDLE
    lsu_if.busReqReady = 1'b0;
    drive(MEM_LOAD, 3'b010, 32'h0000_010C, 32'h0, 5'd4);
    tick();
    lsu_if.inValid = 1'b0;
    lsu_if.flush   = 1'b1;
    tick();
    lsu_if.flush = 1'b0;
    #1;
    check("wdraw_breq", {31'd0, lsu_if.busReqValid}, 32'd0);
    check("wdraw_inready", {31'd0, lsu_if.inReady}, 32'd1);
    check("wdraw_ovalid", {31'd0, lsu_if.outValid}, 32'd0);
    lsu_if.busReqReady = 1'b1;
    tick();

    // Flush beats a simultaneous accept
    drive(MEM_NONE, 3'b000, 32'h0BAD_0BAD, 32'h0, 5'd2);
    lsu_if.flush = 1'b1;
    tick();
    lsu_if.inValid = 1'b0;
    lsu_if.flush   = 1'b0;
    #1;
    check("flush_prio_ovalid", {31'd0, lsu_if.outValid}, 32'd0);
    check("flush_prio_breq", {31'd0, lsu_if.busReqValid}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage of the in-order RV32I pipeline. Sits between execute and writeback.
- Consumes the execute-stage payload (MemoryOperation_, funct3, effective address, store data, rd) and performs at most one data-bus transaction per instruction.
- Aligns and sign/zero-extends load data, builds store byte strobes, and flags misaligned accesses.
- Non-memory instructions pass through with their ALU result.

Parameters:
- ADDR_WIDTH, 32, data-bus address width.
- DATA_WIDTH, 32, data word width; fixed at 32 for RV32I.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  kill the held or accepted instruction (trap/redirect)
- inValid  in  1  execute payload valid
- inReady  out  1  stage can accept
- inMemOp  in  2  MemoryOperation_
- inFunct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- inAddress  in  32  effective address, or ALU result for MEM_NONE
- inStoreData  in  32  rs2 value
- inRd  in  5  destination register
- outValid  out  1  writeback payload valid
- outReady  in  1  writeback accepts
- outResult  out  32  load data or passthrough ALU result
- outRd  out  5  destination register
- outLoadMisaligned  out  1  load address misaligned
- outStoreMisaligned  out  1  store address misaligned
- busReqValid  out  1  data-bus request
- busReqReady  in  1  bus accepts request
- busWrite  out  1  1 = store
- busAddress  out  32  word-aligned address ({addr[31:2],2'b00})
- busWriteData  out  32  store data replicated into lanes
- busWriteStrobe  out  4  byte enables
- busRespValid  in  1  response (load data, or store ack)
- busRespData  in  32  read word

Behaviour:
- Reset values: all outputs 0, state IDLE, inReady 1 in IDLE.
- FSM states: IDLE, REQUEST, WAIT_RESP, HOLD, DRAIN.
- IDLE:
  - inReady = 1. Accept on inValid.
  - MEM_NONE, or a misaligned access: go to HOLD next cycle. outResult = inAddress. The matching misaligned flag is set. No bus activity.
  - Aligned load/store: go to REQUEST. Latch payload.
- Alignment rule: H requires addr[0]=0. W requires addr[1:0]=0. B is always aligned.
- REQUEST:
  - busReqValid = 1. Bus fields stable until busReqReady.
  - On handshake go to WAIT_RESP.
- WAIT_RESP:
  - On busRespValid go to HOLD.
  - Load result = byte/half selected by addr[1:0] and addr[1], sign-extended (B, H) or zero-extended (BU, HU). W passes through.
  - Store: outResult = 0.
- HOLD:
  - outValid = 1. Payload stable while outReady = 0.
  - On outValid && outReady: if inValid, accept the new instruction in the same cycle (back-to-back); else go to IDLE.
  - inReady = outReady in HOLD.
- Store strobes:
  - SB: 4'b0001 << addr[1:0]. SH: 4'b0011 << addr[1:0]. SW: 4'b1111.
  - busWriteData replicates the byte or half across all lanes.
- Minimum latency (bus ready and response in the cycle after request):
  - MEM_NONE: outValid 1 cycle after accept.
  - Load/store: busReqValid 1 cycle after accept; response 1 cycle after handshake; outValid 1 cycle after response (3 cycles total).
- Flush:
  - In IDLE/HOLD: drop the payload, outValid = 0 next cycle, go to IDLE.
  - In REQUEST: if busReqReady is high the same cycle, go to DRAIN; else withdraw the request and go to IDLE.
  - In WAIT_RESP: go to DRAIN.
  - DRAIN: inReady = 0. Discard the response, then go to IDLE. This guarantees no orphaned bus responses.
  - Flush has priority over a simultaneous accept.
- Reset mid-transaction: immediate return to IDLE. The bus must be reset concurrently.
- An illegal funct3 (011, 11x) on a load/store is treated as W.

Decomposition:
- Shared package additions:
  - LoadStoreSize_ enum (LS_BYTE, LS_HALF, LS_WORD, LS_BYTE_U, LS_HALF_U) mapped to funct3.
  - LsuState_ enum for the FSM.
- Reuse MemoryOperation_ as-is.
- One natural sub-module, load_align: combinational extraction and extension from (respData, addr[1:0], size).

Test Plan:
- MEM_NONE, inAddress=0x1234_5678, rd=5, outReady=1 -> outValid next cycle, outResult=0x12345678, outRd=5, no busReqValid.
- LB at addr 0x103, respData=0x80FF_0011 -> outResult=0xFFFFFF80. The same with LBU -> 0x00000080.
- SH at addr 0x202, storeData=0x0000_ABCD -> busAddress=0x200, strobe=4'b1100, busWriteData=0xABCDABCD, busWrite=1.
- LW at addr 0x102 -> outLoadMisaligned=1, no bus request, outValid 1 cycle after accept.
- LW with busReqReady low 3 cycles, outReady low 2 cycles after response -> bus fields and outResult stable throughout; a back-to-back second instruction is accepted on the outReady handshake cycle.
- Flush asserted in WAIT_RESP -> state DRAIN, response discarded, outValid stays 0, inReady=1 the cycle after busRespValid.
